// File: rtl/pipe_skid_stage.sv
// Two-entry in-order skid buffer for a pipeline stage boundary, with stall/flush
// control and saturating stall/bubble statistics counters.
module pipe_skid_stage #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              main_valid;
    logic              skid_valid;
    logic              accept;
    logic              emit;

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);

    // in_ready depends only on local state and hazard inputs, never on out_ready.
    assign in_ready = !skid_valid && !stall && !flush;
    assign accept   = in_valid && in_ready;
    assign emit     = main_valid && out_ready && !stall && !flush;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would let main see skid's new value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            // Payload registers keep their contents so out_data holds its last value.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= ONE;
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (accept) begin
                        state     <= FULL;
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                    end else if (emit) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state     <= ONE;
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!main_valid && !stall && !flush && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_pipe_skid_stage;

    localparam int DATA_W  = 32;
    localparam int CTRL_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic              cnt_clr = 1'b0;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    pipe_skid_stage #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall     (stall),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries plus plain counters.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t            q[$];
    logic [DATA_W-1:0] m_last = '0;
    int                m_stall = 0;
    int                m_bubble = 0;

    task automatic model_reset();
        q.delete();
        m_last   = '0;
        m_stall  = 0;
        m_bubble = 0;
    endtask

    task automatic model_update();
        logic acc;
        logic emt;
        entry_t e;
        acc = in_valid && (q.size() < 2) && !stall && !flush;
        emt = (q.size() > 0) && out_ready && !stall && !flush;
        if (cnt_clr) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (stall && m_stall < CNT_MAX) m_stall++;
            if (q.size() == 0 && !stall && !flush && m_bubble < CNT_MAX) m_bubble++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (emt) q.delete(0);
            if (acc) begin
                e.data = in_data;
                e.ctrl = in_ctrl;
                q.push_back(e);
            end
        end
        if (q.size() > 0) m_last = q[0].data;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready", in_ready, (q.size() < 2) && !stall && !flush);
            check("out_valid", out_valid, q.size() > 0);
            check("out_data", out_data, m_last);
            check("out_ctrl", out_ctrl, (q.size() > 0) ? q[0].ctrl : '0);
            check("stall_cnt", stall_cnt, m_stall);
            check("bubble_cnt", bubble_cnt, m_bubble);
        end
    end

    // Drive one cycle of inputs, advance the model on the edge, return at edge+1.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic ordy, input logic st, input logic fl, input logic clr);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        cnt_clr   = clr;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    initial begin
        // Power-on reset
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_data", out_data, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_bubble_cnt", bubble_cnt, 0);
        rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Streaming: each entry appears one cycle after it is offered
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, DATA_W'(k), CTRL_W'(8'h80 | k), 1'b1, 1'b0, 1'b0, 1'b0);
            check("stream_data", out_data, k);
            check("stream_valid", out_valid, 1);
            check("stream_in_ready", in_ready, 1);
        end
        check("stream_bubble", bubble_cnt, 1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stream_drained", out_valid, 0);

        // Backpressure: fill both entries, then drain in order
        step(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_full_in_ready", in_ready, 0);
        check("bp_head_a", out_data, 32'hA);
        check("bp_head_a_ctrl", out_ctrl, 8'h0A);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_head_b", out_data, 32'hB);
        check("bp_in_ready_back", in_ready, 1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_empty", out_valid, 0);

        // Stall: ONE holding 0x5, stall with out_ready high for three cycles
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h5, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h77, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
            check("stall_hold_data", out_data, 32'h5);
            check("stall_hold_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
        end
        check("stall_cnt_3", stall_cnt, 3);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stall_release_valid", out_valid, 0);
        check("bubble_ctrl_zero", out_ctrl, 0);
        check("bubble_data_held", out_data, 32'h5);

        // Flush from FULL while an input is offered
        step(1'b1, 32'h10, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_pre_full", in_ready, 0);
        step(1'b1, 32'h99, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
        check("flush_valid", out_valid, 0);
        check("flush_ctrl", out_ctrl, 0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("flush_not_taken", out_valid, 0);

        // Counter saturation and clear-over-increment
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("stall_cnt_sat", stall_cnt, 15);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("stall_cnt_clr", stall_cnt, 0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while FULL
        step(1'b1, 32'hA1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hA2, 8'hC2, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_pre_valid", out_valid, 1);
        idle_inputs();
        out_ready = 1'b1;
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ctrl", out_ctrl, 0);
        check("mid_rst_data", out_data, 0);
        rst = 1'b1;
        #1;
        check("mid_rel_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("mid_no_old_entry", out_valid, 0);
        end

        // Randomized traffic, checked each cycle by the model comparison
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(1) == 1, $urandom, CTRL_W'($urandom_range(255)),
                 $urandom_range(9) < 6, $urandom_range(7) == 0,
                 $urandom_range(15) == 0, $urandom_range(15) == 0);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64: payload width (PC, ALU result, load data, rd packed by the instantiating stage).
REQ-002 SHALL have parameter CTRL_W, default 8: width of the control bundle (RegWrite, WDSel, ...); bit value 0 means no-op.
REQ-003 SHALL have parameter CNT_W, default 16: width of each statistics counter.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream entry present.
REQ-007 SHALL have port in_ready, output, 1 bit: stage can accept an entry this cycle.
REQ-008 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-009 SHALL have port in_ctrl, input, CTRL_W bits: upstream control bundle.
REQ-010 SHALL have port out_valid, output, 1 bit: head entry present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the head entry.
REQ-012 SHALL have port out_data, output, DATA_W bits: head payload.
REQ-013 SHALL have port out_ctrl, output, CTRL_W bits: head control bundle.
REQ-014 SHALL have port stall, input, 1 bit: freeze the stage (hazard unit).
REQ-015 SHALL have port flush, input, 1 bit: discard all held entries (branch/exception).
REQ-016 SHALL have port cnt_clr, input, 1 bit: synchronous clear of both counters.
REQ-017 SHALL have port stall_cnt, output, CNT_W bits: count of stall cycles.
REQ-018 SHALL have port bubble_cnt, output, CNT_W bits: count of bubble cycles.

Function
REQ-019 SHALL implement a 2-entry in-order buffer (main and skid registers), with states EMPTY, ONE (main valid) and FULL (main and skid valid).
REQ-020 SHALL drive in_ready = !skid_valid && !stall && !flush, with no combinational path from out_ready.
REQ-021 SHALL define accept = in_valid && in_ready and emit = out_valid && out_ready && !stall && !flush.
REQ-022 SHALL, in EMPTY: accept -> ONE, main <= input.
REQ-023 SHALL, in ONE: accept && emit -> ONE, main <= input; accept && !emit -> FULL, skid <= input; !accept && emit -> EMPTY.
REQ-024 SHALL, in FULL: emit -> ONE, main <= skid; otherwise hold.
REQ-025 SHALL give a latency of 1 cycle from accept to out_valid when the stage was EMPTY, or ONE with emit in the same cycle.
REQ-026 SHALL drive out_valid = main_valid, out_data = main data, out_ctrl = main ctrl when valid.
REQ-027 SHALL force out_ctrl to all-zero when out_valid = 0 (bubble = no-op); out_data then holds its last value.
REQ-028 SHALL, when stall = 1, hold all entries, take no accept and no emit, and keep out_valid, out_data and out_ctrl unchanged.
REQ-029 SHALL, when flush = 1, go to EMPTY at the next edge and clear both valid bits; flush has priority over stall and over in_valid.
REQ-030 SHALL deliver entries strictly in arrival order, with no duplication and no loss except by flush.
REQ-031 SHALL increment stall_cnt in each cycle with stall = 1.
REQ-032 SHALL increment bubble_cnt in each cycle with out_valid = 0, stall = 0 and flush = 0.
REQ-033 SHALL saturate both counters at 2^CNT_W-1, with no wrap.
REQ-034 SHALL let cnt_clr override any increment in the same cycle, zeroing both counters.

Reset
REQ-035 SHALL, while rst = 0 (asynchronously), set state EMPTY, clear main and skid data/ctrl to 0, out_valid = 0, out_ctrl = 0, out_data = 0, stall_cnt = 0, bubble_cnt = 0.
REQ-036 SHALL drive in_ready = 1 once rst = 1, provided stall = 0 and flush = 0.
REQ-037 SHALL, when reset is asserted mid-transfer, discard all held entries with no partial output.

Verification
REQ-038 SHALL verify streaming: in_valid = 1 with data 1,2,3,...; out_ready = 1 -> out_data = 1,2,3 one cycle later each; in_ready stays 1; bubble_cnt = 1 (first cycle only).
REQ-039 SHALL verify backpressure: send 0xA then 0xB with out_ready = 0 -> state FULL, in_ready = 0; then out_ready = 1 -> out 0xA then 0xB; in_ready returns 1 after 0xA leaves.
REQ-040 SHALL verify stall: stage ONE holding 0x5, stall = 1 for 3 cycles with out_ready = 1 -> out_data stays 0x5, no emit, stall_cnt = 3, in_ready = 0.
REQ-041 SHALL verify flush: stage FULL, flush = 1 with in_valid = 1 -> next cycle out_valid = 0, out_ctrl = 0, the offered input is not taken.
REQ-042 SHALL verify counter saturation: CNT_W = 4, stall held 20 cycles -> stall_cnt = 15; cnt_clr = 1 while stall = 1 -> stall_cnt = 0.
REQ-043 SHALL verify mid-operation reset: stage FULL, rst pulsed low between edges -> out_valid = 0 immediately; after release in_ready = 1 and the old entries never appear.
